// File: rtl/instr_fetch.sv
// Instruction-fetch reader: takes one fetch per entry into the control FSM's
// fetch state, runs a req/ack read on the instruction memory port, and holds
// the fetched word for decode/execute. Misaligned, bus-error and timeout
// faults are latched until fault_clr.
//
// Memory handshake: imem_req and imem_addr rise together and stay constant
// until the first cycle in which imem_ack is sampled high; imem_rdata and
// imem_err are only looked at in that cycle. imem_ack seen while not
// requesting is ignored, and a request is never withdrawn early except by
// reset.
module instr_fetch #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         state,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               fault_clr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_err,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               fetch_busy,
  output logic               fetch_fault,
  output logic [1:0]         fault_cause,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } fsm_t;

  localparam logic [2:0] FETCH_STATE = 3'b000;
  // Counter value seen on the last request cycle allowed before timing out.
  localparam logic [7:0] LAST_CNT    = 8'(TIMEOUT - 1);

  fsm_t       cur;
  logic       armed;
  logic [7:0] cnt;

  // Debug view of the FSM state for checkers.
  assign fsm_state = cur;

  // Fetch FSM with all outputs registered; armed guarantees one fetch per
  // entry into the fetch state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= IDLE;
      armed       <= 1'b1;
      cnt         <= 8'd0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_busy  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      if (state != FETCH_STATE) begin
        armed <= 1'b1;
      end
      case (cur)
        IDLE: begin
          if (state == FETCH_STATE && armed) begin
            armed       <= 1'b0;
            instr_valid <= 1'b0;
            if (pc[1:0] != 2'b00) begin
              // Misaligned: fault without ever touching the bus.
              fetch_fault <= 1'b1;
              fault_cause <= 2'b01;
              cur         <= FAULT;
            end else begin
              imem_addr  <= pc;
              imem_req   <= 1'b1;
              fetch_busy <= 1'b1;
              cnt        <= 8'd0;
              cur        <= REQ;
            end
          end
        end
        REQ: begin
          // An ack always beats the timeout, even on the final cycle.
          if (imem_ack) begin
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            if (imem_err) begin
              fetch_fault <= 1'b1;
              fault_cause <= 2'b11;
              cur         <= FAULT;
            end else begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              cur         <= DONE;
            end
          end else if (cnt == LAST_CNT) begin
            imem_req    <= 1'b0;
            fetch_busy  <= 1'b0;
            fetch_fault <= 1'b1;
            fault_cause <= 2'b10;
            cur         <= FAULT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          cur <= IDLE;
        end
        FAULT: begin
          // fault_clr only acts once the fault is already latched.
          if (fault_clr) begin
            fetch_fault <= 1'b0;
            fault_cause <= 2'b00;
            cur         <= IDLE;
          end
        end
        default: begin
          cur <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a short timeout (TIMEOUT = 4).
// Inputs change just after the falling edge; outputs are checked at the
// following falling edge, i.e. after the intervening rising edge.
module tb_instr_fetch;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int TO      = 4;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_REQ   = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  logic               clk;
  logic               reset;
  logic [2:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic               fault_clr;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_err;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               fetch_busy;
  logic               fetch_fault;
  logic [1:0]         fault_cause;
  logic [1:0]         fsm_state;

  int checks = 0;
  int errors = 0;
  int req_seen;

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .state(state), .pc(pc), .fault_clr(fault_clr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .instr(instr),
    .instr_valid(instr_valid), .fetch_busy(fetch_busy),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   64'(imem_req),    64'd0);
    check({tag, "_addr"},  imem_addr,        64'd0);
    check({tag, "_instr"}, 64'(instr),       64'd0);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_busy"},  64'(fetch_busy),  64'd0);
    check({tag, "_fault"}, 64'(fetch_fault), 64'd0);
    check({tag, "_cause"}, 64'(fault_cause), 64'd0);
    check({tag, "_fsm"},   64'(fsm_state),   64'(S_IDLE));
  endtask

  initial begin
    reset      = 1'b0;
    state      = 3'b001;
    pc         = '0;
    fault_clr  = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    imem_err   = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b1;
    tick();

    // Fetch at 0x1000, ack on the 3rd request cycle.
    state = 3'b000;
    pc    = 64'h1000;
    tick();
    check("f1_addr", imem_addr, 64'h1000);
    check("f1_busy", 64'(fetch_busy), 64'd1);
    check("f1_valid_cleared", 64'(instr_valid), 64'd0);
    check("f1_req_c1", 64'(imem_req), 64'd1);
    tick();
    check("f1_req_c2", 64'(imem_req), 64'd1);
    tick();
    check("f1_req_c3", 64'(imem_req), 64'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hffff_ffff;
    check("f1_req_drop", 64'(imem_req), 64'd0);
    check("f1_instr", 64'(instr), 64'h0050_0093);
    check("f1_valid", 64'(instr_valid), 64'd1);
    check("f1_fault", 64'(fetch_fault), 64'd0);
    check("f1_fsm_done", 64'(fsm_state), 64'(S_DONE));

    // Holding the fetch state must not start another fetch.
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req) req_seen++;
    end
    check("hold_no_refetch", 64'(req_seen), 64'd0);
    check("hold_instr_kept", 64'(instr), 64'h0050_0093);
    check("hold_valid_kept", 64'(instr_valid), 64'd1);

    // Leave and re-enter fetch at 0x1004; ack in the first request cycle.
    state = 3'b001;
    tick();
    state = 3'b000;
    pc    = 64'h1004;
    tick();
    check("f2_req", 64'(imem_req), 64'd1);
    check("f2_addr", imem_addr, 64'h1004);
    check("f2_valid_cleared", 64'(instr_valid), 64'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00a0_0113;
    tick();
    imem_ack = 1'b0;
    check("f2_instr", 64'(instr), 64'h00a0_0113);
    check("f2_valid", 64'(instr_valid), 64'd1);
    check("f2_req_drop", 64'(imem_req), 64'd0);

    // Misaligned pc: fault next cycle, no request.
    state = 3'b001;
    tick();
    state = 3'b000;
    pc    = 64'h1002;
    tick();
    check("mis_req", 64'(imem_req), 64'd0);
    check("mis_fault", 64'(fetch_fault), 64'd1);
    check("mis_cause", 64'(fault_cause), 64'd1);
    check("mis_valid", 64'(instr_valid), 64'd0);
    check("mis_addr_kept", imem_addr, 64'h1004);
    check("mis_fsm", 64'(fsm_state), 64'(S_FAULT));
    tick();
    check("mis_sticky", 64'(fetch_fault), 64'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("mis_clr_fault", 64'(fetch_fault), 64'd0);
    check("mis_clr_cause", 64'(fault_cause), 64'd0);
    check("mis_clr_fsm", 64'(fsm_state), 64'(S_IDLE));
    tick();
    check("mis_no_retry", 64'(imem_req), 64'd0);
    check("mis_valid_stays0", 64'(instr_valid), 64'd0);

    // Timeout: request held exactly TO cycles; fault_clr coinciding with
    // the fault edge is ignored.
    state = 3'b001;
    tick();
    state = 3'b000;
    pc    = 64'h2000;
    tick();
    req_seen = 0;
    for (int i = 0; i < TO; i++) begin
      if (imem_req) req_seen++;
      if (i == TO - 1) fault_clr = 1'b1;
      tick();
    end
    fault_clr = 1'b0;
    check("to_req_cycles", 64'(req_seen), 64'(TO));
    check("to_req_drop", 64'(imem_req), 64'd0);
    check("to_fault", 64'(fetch_fault), 64'd1);
    check("to_cause", 64'(fault_cause), 64'd2);
    check("to_busy", 64'(fetch_busy), 64'd0);
    tick();
    check("to_clr_ignored", 64'(fetch_fault), 64'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("to_clr", 64'(fetch_fault), 64'd0);

    // Ack on the TO-th request cycle wins over the timeout.
    state = 3'b001;
    tick();
    state = 3'b000;
    pc    = 64'h2004;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    check("late_ack_req", 64'(imem_req), 64'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("late_ack_fault", 64'(fetch_fault), 64'd0);
    check("late_ack_instr", 64'(instr), 64'h1234_5678);
    check("late_ack_valid", 64'(instr_valid), 64'd1);

    // Bus error: cause 11, instr keeps its old value.
    state = 3'b001;
    tick();
    state = 3'b000;
    pc    = 64'h3000;
    tick();
    imem_ack   = 1'b1;
    imem_err   = 1'b1;
    imem_rdata = 32'hdead_beef;
    tick();
    imem_ack = 1'b0;
    imem_err = 1'b0;
    check("err_fault", 64'(fetch_fault), 64'd1);
    check("err_cause", 64'(fault_cause), 64'd3);
    check("err_instr_kept", 64'(instr), 64'h1234_5678);
    check("err_valid", 64'(instr_valid), 64'd0);
    check("err_req", 64'(imem_req), 64'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("err_clr", 64'(fetch_fault), 64'd0);

    // Reset in the middle of a request drops everything at once.
    state = 3'b001;
    tick();
    state = 3'b000;
    pc    = 64'h4000;
    tick();
    check("mid_req_up", 64'(imem_req), 64'd1);
    state = 3'b010;
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    tick();
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hffff_ffff;
    tick();
    imem_ack = 1'b0;
    check("stray_ack_instr", 64'(instr), 64'd0);
    check("stray_ack_valid", 64'(instr_valid), 64'd0);
    check("stray_ack_fsm", 64'(fsm_state), 64'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
